// File: rtl/fast_fifo_pkg.sv
// Shared definitions for the fast_fifo_2_cell pixel delay line.
//   PIXEL_WIDTH : default pixel width in bits
//   count_width : width of an occupancy counter able to hold 0..depth
//   pixel_t     : one default-width pixel
package fast_fifo_pkg;

    localparam int unsigned PIXEL_WIDTH = 8;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_cell.sv
// One pixel stage of the delay line: a DATA_WIDTH register with a load enable.
// Ports:
//   CLK    : clock, rising edge
//   Reset  : synchronous active-high clear
//   Enable : load D on the rising edge, otherwise hold
//   D      : next pixel value
//   Q      : registered pixel value
module fifo_cell #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (Enable) begin
            q_d = D;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/fast_fifo_2_cell.sv
// Fixed-latency shift-register FIFO (delay line) of DEPTH pixel cells for the
// Sobel pipeline. Every enabled edge shifts DataIn into cell 0 and moves each
// cell one stage toward DataOut; disabled edges hold everything.
// Ports:
//   CLK     : clock, rising edge
//   Reset   : synchronous active-high reset, overrides Enable
//   Enable  : shift enable
//   DataIn  : pixel captured into cell 0 on an enabled edge
//   DataOut : oldest cell (cell DEPTH-1), straight from its register
//   Valid   : high once DEPTH enabled shifts have happened since reset
//   Count   : enabled shifts since reset, saturating at DEPTH
//   Taps    : only with FAST_FIFO_TAP_OUT_EN defined; all cells packed with
//             cell 0 in the LSBs and cell DEPTH-1 in the MSBs
module fast_fifo_2_cell
    import fast_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIXEL_WIDTH,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          Enable,
    input  logic [DATA_WIDTH-1:0]         DataIn,
    output logic [DATA_WIDTH-1:0]         DataOut,
    output logic                          Valid,
    output logic [count_width(DEPTH)-1:0] Count
`ifdef FAST_FIFO_TAP_OUT_EN
    ,
    output logic [DEPTH*DATA_WIDTH-1:0]   Taps
`endif
);

    localparam int unsigned CountW = count_width(DEPTH);
    localparam logic [CountW-1:0] CountMax = CountW'(DEPTH);

    logic [DATA_WIDTH-1:0] cell_out [DEPTH];
    logic [CountW-1:0]     count_q, count_d;

    // Cell chain: cell 0 takes DataIn, every later cell takes its predecessor.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [DATA_WIDTH-1:0] cell_in;
        if (i == 0) begin : g_head
            assign cell_in = DataIn;
        end else begin : g_link
            assign cell_in = cell_out[i-1];
        end

        fifo_cell #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cell (
            .CLK    (CLK),
            .Reset  (Reset),
            .Enable (Enable),
            .D      (cell_in),
            .Q      (cell_out[i])
        );
    end

    // Occupancy counter saturates at DEPTH so Valid stays up until reset.
    always_comb begin
        count_d = count_q;
        if (Enable && (count_q != CountMax)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign DataOut = cell_out[DEPTH-1];
    assign Count   = count_q;
    assign Valid   = (count_q == CountMax);

`ifdef FAST_FIFO_TAP_OUT_EN
    for (genvar t = 0; t < DEPTH; t++) begin : g_tap
        assign Taps[t*DATA_WIDTH +: DATA_WIDTH] = cell_out[t];
    end
`else
    // Without taps the intermediate cells are only observable through the chain.
`endif

endmodule

// File: tb/tb_fast_fifo_2_cell.sv
module tb_fast_fifo_2_cell;
    import fast_fifo_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          Enable = 1'b0;
    logic [DW-1:0] DataIn = '0;
    logic [DW-1:0] DataOut;
    logic          Valid;
    logic [CW-1:0] Count;
`ifdef FAST_FIFO_TAP_OUT_EN
    logic [DEPTH*DW-1:0] Taps;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    fast_fifo_2_cell #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Enable  (Enable),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .Valid   (Valid),
        .Count   (Count)
`ifdef FAST_FIFO_TAP_OUT_EN
        ,
        .Taps    (Taps)
`endif
    );

    always #30 CLK = ~CLK;

    // Reference model: the last DEPTH pixels accepted since reset, plus the
    // number of accepted pixels (saturated). Oldest entry is hist[0].
    pixel_t hist[$];
    int     shifts = 0;

    always @(posedge CLK) begin
        if (Reset) begin
            hist.delete();
            shifts = 0;
        end else if (Enable) begin
            hist.push_back(DataIn);
            if (hist.size() > DEPTH) void'(hist.pop_front());
            if (shifts < DEPTH) shifts++;
        end
    end

    function automatic logic [31:0] exp_out();
        return (hist.size() == DEPTH) ? 32'(hist[0]) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_tap(input int i);
        return (hist.size() > i) ? 32'(hist[hist.size()-1-i]) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".DataOut"}, 32'(DataOut), exp_out());
        chk({tag, ".Count"}, 32'(Count), 32'(shifts));
        chk({tag, ".Valid"}, 32'(Valid), 32'(shifts == DEPTH));
`ifdef FAST_FIFO_TAP_OUT_EN
        for (int i = 0; i < DEPTH; i++) begin
            chk({tag, ".Taps"}, 32'(Taps[i*DW +: DW]), exp_tap(i));
        end
`endif
    endtask

    // Drive between edges, then return just after the next rising edge.
    task automatic step(input logic r, input logic e, input logic [DW-1:0] d);
        @(negedge CLK);
        Reset  = r;
        Enable = e;
        DataIn = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] fill [3];
        logic [DW-1:0] fill_exp [3];
        logic [CW-1:0] fill_cnt [3];
        fill     = '{8'hA5, 8'h3C, 8'hFF};
        fill_exp = '{8'h00, 8'hA5, 8'h3C};
        fill_cnt = '{1, 2, 2};

        // Reset then fill
        step(1'b1, 1'b1, 8'h77);
        step(1'b1, 1'b0, 8'h00);
        chk("reset.DataOut", 32'(DataOut), 32'd0);
        chk("reset.Count", 32'(Count), 32'd0);
        chk("reset.Valid", 32'(Valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, fill[i]);
            chk("fill.DataOut", 32'(DataOut), 32'(fill_exp[i]));
            chk("fill.Count", 32'(Count), 32'(fill_cnt[i]));
            chk("fill.Valid", 32'(Valid), 32'(i >= 1));
            chk_model("fill");
        end

        // Hold with DataIn toggling
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, DW'($urandom));
            chk("hold.DataOut", 32'(DataOut), 32'h3C);
            chk("hold.Count", 32'(Count), 32'd2);
            #7 DataIn = DW'($urandom);
        end
        step(1'b0, 1'b1, 8'h11);
        chk("hold.resume", 32'(DataOut), 32'hFF);

        // Mid-operation reset with Enable high
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b1, 8'h34);
        chk_model("full");
        step(1'b1, 1'b1, 8'h56);
        chk("midrst.DataOut", 32'(DataOut), 32'd0);
        chk("midrst.Count", 32'(Count), 32'd0);
        chk("midrst.Valid", 32'(Valid), 32'd0);
        // Enable already high as Reset drops: first shift is this edge's data
        step(1'b0, 1'b1, 8'h9A);
        chk("postrst.Count", 32'(Count), 32'd1);
        chk_model("postrst");

        // Gapped enable: Enable toggles every 200, DataIn every 20, CLK period 60.
        // Starting on a falling edge keeps every input change off the rising edge.
        @(negedge CLK);
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    Enable = ~Enable;
                    #200;
                end
            end
            begin
                for (int k = 0; k < 120; k++) begin
                    DataIn = DW'($urandom);
                    #20;
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge CLK);
                    #1;
                    chk_model("gap");
                end
            end
        join

        // Streaming from reset, DataIn = cycle index
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, DW'(i));
            if (i >= DEPTH - 1) begin
                chk("stream.DataOut", 32'(DataOut), 32'((i - (DEPTH - 1)) % 256));
            end
            chk("stream.Count", 32'(Count), 32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
            chk_model("stream");
        end

`ifdef FAST_FIFO_TAP_OUT_EN
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h20);
        chk("taps.Taps", 32'(Taps), 32'h1020);
        chk("taps.DataOut", 32'(DataOut), 32'h10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
